// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, functs,
// FSM state encodings, instruction classes and datapath control codes.
package mips_pkg;

    localparam int unsigned OP_W       = 6;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned ALU_CODE_W = 4;
    localparam int unsigned NPC_CODE_W = 3;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned MDU_OP_W   = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;
    localparam logic [OP_W-1:0] FN_MFHI  = 6'b010000;
    localparam logic [OP_W-1:0] FN_MTHI  = 6'b010001;
    localparam logic [OP_W-1:0] FN_MFLO  = 6'b010010;
    localparam logic [OP_W-1:0] FN_MTLO  = 6'b010011;
    localparam logic [OP_W-1:0] FN_MULT  = 6'b011000;
    localparam logic [OP_W-1:0] FN_MULTU = 6'b011001;
    localparam logic [OP_W-1:0] FN_DIV   = 6'b011010;
    localparam logic [OP_W-1:0] FN_DIVU  = 6'b011011;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXE      = 3'd2,
        ST_MEM      = 3'd3,
        ST_WB       = 3'd4,
        ST_MDU_WAIT = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        IC_ILLEGAL,
        IC_ADDU,
        IC_SUBU,
        IC_ORI,
        IC_LUI,
        IC_LW,
        IC_SW,
        IC_BEQ,
        IC_J,
        IC_JAL,
        IC_JR,
        IC_MDU_START,
        IC_MFHILO,
        IC_MTHILO
    } iclass_e;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0010;

    localparam logic [NPC_CODE_W-1:0] NPC_PC4  = 3'b000;
    localparam logic [NPC_CODE_W-1:0] NPC_BEQ  = 3'b001;
    localparam logic [NPC_CODE_W-1:0] NPC_JUMP = 3'b010;
    localparam logic [NPC_CODE_W-1:0] NPC_JR   = 3'b011;

    localparam logic [SEL_W-1:0] DST_RT = 2'b00;
    localparam logic [SEL_W-1:0] DST_RD = 2'b01;
    localparam logic [SEL_W-1:0] DST_RA = 2'b10;

    localparam logic [SEL_W-1:0] WB_ALU  = 2'b00;
    localparam logic [SEL_W-1:0] WB_DM   = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC4  = 2'b10;
    localparam logic [SEL_W-1:0] WB_HILO = 2'b11;

    localparam logic [SEL_W-1:0] EXT_ZERO = 2'b00;
    localparam logic [SEL_W-1:0] EXT_SIGN = 2'b01;
    localparam logic [SEL_W-1:0] EXT_LUI  = 2'b10;

    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 3'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 3'd7;

    typedef struct packed {
        logic                  pc_write;
        logic                  ir_write;
        logic                  reg_write;
        logic                  mem_write;
        logic                  alu_src;
        logic [SEL_W-1:0]      reg_dst;
        logic [SEL_W-1:0]      mem_to_reg;
        logic [SEL_W-1:0]      ext_op;
        logic [ALU_CODE_W-1:0] alu_op;
        logic [NPC_CODE_W-1:0] npc_op;
        logic                  illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational Op/Func classifier for multi_ctrl; MULTI_CTRL_MDU_EN adds
// the multiply/divide and HI/LO move instructions.
module ctrl_decode
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]     op_i,
    input  logic [OP_W-1:0]     func_i,
`ifdef MULTI_CTRL_MDU_EN
    output logic [MDU_OP_W-1:0] mdu_op_o,
`endif
    output iclass_e             iclass_o,
    output logic                illegal_o
);

    always_comb begin
        iclass_o = IC_ILLEGAL;
`ifdef MULTI_CTRL_MDU_EN
        mdu_op_o = '0;
`endif
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADDU:  iclass_o = IC_ADDU;
                    FN_SUBU:  iclass_o = IC_SUBU;
                    FN_JR:    iclass_o = IC_JR;
`ifdef MULTI_CTRL_MDU_EN
                    FN_MULT:  begin iclass_o = IC_MDU_START; mdu_op_o = MDU_MULT;  end
                    FN_MULTU: begin iclass_o = IC_MDU_START; mdu_op_o = MDU_MULTU; end
                    FN_DIV:   begin iclass_o = IC_MDU_START; mdu_op_o = MDU_DIV;   end
                    FN_DIVU:  begin iclass_o = IC_MDU_START; mdu_op_o = MDU_DIVU;  end
                    FN_MTHI:  begin iclass_o = IC_MTHILO;    mdu_op_o = MDU_MTHI;  end
                    FN_MTLO:  begin iclass_o = IC_MTHILO;    mdu_op_o = MDU_MTLO;  end
                    FN_MFHI:  begin iclass_o = IC_MFHILO;    mdu_op_o = MDU_MFHI;  end
                    FN_MFLO:  begin iclass_o = IC_MFHILO;    mdu_op_o = MDU_MFLO;  end
`endif
                    default:  iclass_o = IC_ILLEGAL;
                endcase
            end
            OP_ORI:  iclass_o = IC_ORI;
            OP_LUI:  iclass_o = IC_LUI;
            OP_LW:   iclass_o = IC_LW;
            OP_SW:   iclass_o = IC_SW;
            OP_BEQ:  iclass_o = IC_BEQ;
            OP_J:    iclass_o = IC_J;
            OP_JAL:  iclass_o = IC_JAL;
            default: iclass_o = IC_ILLEGAL;
        endcase
    end

    assign illegal_o = (iclass_o == IC_ILLEGAL);

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXE/MEM/WB/MDU_WAIT).
// Define MULTI_CTRL_MDU_EN to add the MDU instructions and their ports.
module multi_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned NPCOP_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     Op,
    input  logic [OP_W-1:0]     Func,
    input  logic                Zero,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                ALUSrc,
    output logic [SEL_W-1:0]    RegDst,
    output logic [SEL_W-1:0]    MemtoReg,
    output logic [SEL_W-1:0]    ExtOp,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [NPCOP_W-1:0]  NPCOp,
    output logic [STATE_W-1:0]  State,
    output logic                Illegal
`ifdef MULTI_CTRL_MDU_EN
    ,
    input  logic                MDUBusy,
    output logic                MDUStart,
    output logic [MDU_OP_W-1:0] MDUOp,
    output logic                HiLoWrite
`endif
);

    state_e  state_q, state_d;
    ctrl_t   ctrl_c;
    iclass_e iclass;
    logic    dec_illegal;
    logic    mdu_busy;

`ifdef MULTI_CTRL_MDU_EN
    logic                mdu_start_c;
    logic                hilo_write_c;
    logic [MDU_OP_W-1:0] mdu_op_c;
    logic [MDU_OP_W-1:0] dec_mdu_op;

    assign mdu_busy = MDUBusy;
`else
    assign mdu_busy = 1'b0;
`endif

    ctrl_decode u_decode (
        .op_i      (Op),
        .func_i    (Func),
`ifdef MULTI_CTRL_MDU_EN
        .mdu_op_o  (dec_mdu_op),
`endif
        .iclass_o  (iclass),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore controls; everything is forced quiet while reset is low.
    always_comb begin
        state_d = ST_FETCH;
        ctrl_c  = '0;
`ifdef MULTI_CTRL_MDU_EN
        mdu_start_c  = 1'b0;
        hilo_write_c = 1'b0;
        mdu_op_c     = '0;
`endif
        case (state_q)
            ST_FETCH: begin
                ctrl_c.ir_write = 1'b1;
                ctrl_c.pc_write = 1'b1;
                ctrl_c.npc_op   = NPC_PC4;
                state_d         = ST_DECODE;
            end
            ST_DECODE: begin
                ctrl_c.illegal = dec_illegal;
                case (iclass)
                    IC_J: begin
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.npc_op   = NPC_JUMP;
                    end
                    IC_JAL: begin
                        ctrl_c.pc_write   = 1'b1;
                        ctrl_c.npc_op     = NPC_JUMP;
                        ctrl_c.reg_write  = 1'b1;
                        ctrl_c.reg_dst    = DST_RA;
                        ctrl_c.mem_to_reg = WB_PC4;
                    end
                    IC_JR: begin
                        ctrl_c.pc_write = 1'b1;
                        ctrl_c.npc_op   = NPC_JR;
                    end
                    IC_ILLEGAL: state_d = ST_FETCH;
                    IC_MFHILO:  state_d = mdu_busy ? ST_MDU_WAIT : ST_WB;
                    IC_MTHILO:  state_d = mdu_busy ? ST_MDU_WAIT : ST_EXE;
                    default:    state_d = ST_EXE;
                endcase
            end
            ST_EXE: begin
                case (iclass)
                    IC_ADDU: begin
                        ctrl_c.alu_op = ALU_ADD;
                        state_d       = ST_WB;
                    end
                    IC_SUBU: begin
                        ctrl_c.alu_op = ALU_SUB;
                        state_d       = ST_WB;
                    end
                    IC_ORI: begin
                        ctrl_c.alu_op  = ALU_OR;
                        ctrl_c.alu_src = 1'b1;
                        ctrl_c.ext_op  = EXT_ZERO;
                        state_d        = ST_WB;
                    end
                    IC_LUI: begin
                        ctrl_c.alu_op  = ALU_OR;
                        ctrl_c.alu_src = 1'b1;
                        ctrl_c.ext_op  = EXT_LUI;
                        state_d        = ST_WB;
                    end
                    IC_LW, IC_SW: begin
                        ctrl_c.alu_op  = ALU_ADD;
                        ctrl_c.alu_src = 1'b1;
                        ctrl_c.ext_op  = EXT_SIGN;
                        state_d        = ST_MEM;
                    end
                    IC_BEQ: begin
                        ctrl_c.alu_op   = ALU_SUB;
                        ctrl_c.pc_write = Zero;
                        ctrl_c.npc_op   = NPC_BEQ;
                    end
`ifdef MULTI_CTRL_MDU_EN
                    IC_MDU_START: begin
                        mdu_start_c = 1'b1;
                        mdu_op_c    = dec_mdu_op;
                    end
                    IC_MTHILO: begin
                        hilo_write_c = 1'b1;
                        mdu_op_c     = dec_mdu_op;
                    end
`endif
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (iclass == IC_LW) begin
                    state_d = ST_WB;
                end else if (iclass == IC_SW) begin
                    ctrl_c.mem_write = 1'b1;
                end
            end
            ST_WB: begin
                case (iclass)
                    IC_ADDU, IC_SUBU: begin
                        ctrl_c.reg_write = 1'b1;
                        ctrl_c.reg_dst   = DST_RD;
                    end
                    IC_ORI, IC_LUI: begin
                        ctrl_c.reg_write  = 1'b1;
                        ctrl_c.reg_dst    = DST_RT;
                        ctrl_c.mem_to_reg = WB_ALU;
                    end
                    IC_LW: begin
                        ctrl_c.reg_write  = 1'b1;
                        ctrl_c.mem_to_reg = WB_DM;
                    end
                    IC_MFHILO: begin
                        ctrl_c.reg_write  = 1'b1;
                        ctrl_c.reg_dst    = DST_RD;
                        ctrl_c.mem_to_reg = WB_HILO;
`ifdef MULTI_CTRL_MDU_EN
                        mdu_op_c          = dec_mdu_op;
`endif
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MDU_WAIT: begin
                if (mdu_busy) begin
                    state_d = ST_MDU_WAIT;
                end else if (iclass == IC_MFHILO) begin
                    state_d = ST_WB;
                end else if (iclass == IC_MTHILO) begin
                    state_d = ST_EXE;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        if (!reset) begin
            ctrl_c = '0;
`ifdef MULTI_CTRL_MDU_EN
            mdu_start_c  = 1'b0;
            hilo_write_c = 1'b0;
            mdu_op_c     = '0;
`endif
        end
    end

    assign PCWrite  = ctrl_c.pc_write;
    assign IRWrite  = ctrl_c.ir_write;
    assign RegWrite = ctrl_c.reg_write;
    assign MemWrite = ctrl_c.mem_write;
    assign ALUSrc   = ctrl_c.alu_src;
    assign RegDst   = ctrl_c.reg_dst;
    assign MemtoReg = ctrl_c.mem_to_reg;
    assign ExtOp    = ctrl_c.ext_op;
    assign ALUOp    = ALUOP_W'(ctrl_c.alu_op);
    assign NPCOp    = NPCOP_W'(ctrl_c.npc_op);
    assign State    = STATE_W'(state_q);
    assign Illegal  = ctrl_c.illegal;

`ifdef MULTI_CTRL_MDU_EN
    assign MDUStart  = mdu_start_c;
    assign MDUOp     = mdu_op_c;
    assign HiLoWrite = hilo_write_c;
`endif

endmodule
